// File: rtl/tape_pkg.sv
// Shared definitions for the tape seek sequencer: controller states,
// default geometry/timing constants and a transport status helper.
package tape_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEEK_FWD = 3'd1,
        SEEK_REW = 3'd2,
        STOPPING = 3'd3,
        PLAY_ARM = 3'd4,
        PLAY     = 3'd5,
        ERR      = 3'd6
    } tape_state_e;

    localparam int DEF_W        = 16;
    localparam int DEF_TAPE_LEN = 4096;
    localparam int DEF_FF_STEP  = 4;
    localparam int DEF_RW_STEP  = 4;
    localparam int DEF_ACK_TO   = 8;

    // More than one of play/reverse/forward reported at once is a transport fault.
    function automatic logic multi_hot3(input logic p, input logic r, input logic f);
        return (p & r) | (p & f) | (r & f);
    endfunction

endpackage

// File: rtl/tape_pos_ctr.sv
// Saturating tape position tracker driven by the transport motion status.
// Pos and Eot are both registered from the same next-position value so they
// always agree in the same cycle.
module tape_pos_ctr
    import tape_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int TAPE_LEN = DEF_TAPE_LEN,
    parameter int FF_STEP  = DEF_FF_STEP,
    parameter int RW_STEP  = DEF_RW_STEP
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         P,
    input  logic         R,
    input  logic         F,
    output logic [W-1:0] Pos,
    output logic         Eot
);

    localparam logic [W:0] LAST_POS = (W+1)'(TAPE_LEN - 1);
    localparam logic [W:0] FF_INC   = (W+1)'(FF_STEP);
    localparam logic [W:0] RW_DEC   = (W+1)'(RW_STEP);
    localparam logic [W:0] PL_INC   = (W+1)'(1);

    logic [W:0] pos_ext_s;
    logic [W:0] nxt_pos_s;

    // Next position: hold on a status fault, otherwise step and clamp to the tape ends.
    always_comb begin
        pos_ext_s = {1'b0, Pos};
        nxt_pos_s = pos_ext_s;
        if (multi_hot3(P, R, F)) begin
            nxt_pos_s = pos_ext_s;
        end else if (F) begin
            if ((pos_ext_s + FF_INC) > LAST_POS) begin
                nxt_pos_s = LAST_POS;
            end else begin
                nxt_pos_s = pos_ext_s + FF_INC;
            end
        end else if (R) begin
            if (pos_ext_s < RW_DEC) begin
                nxt_pos_s = {(W+1){1'b0}};
            end else begin
                nxt_pos_s = pos_ext_s - RW_DEC;
            end
        end else if (P) begin
            if (pos_ext_s >= LAST_POS) begin
                nxt_pos_s = LAST_POS;
            end else begin
                nxt_pos_s = pos_ext_s + PL_INC;
            end
        end else begin
            nxt_pos_s = pos_ext_s;
        end
    end

    // Position and end-of-tape flag registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Pos <= {W{1'b0}};
            Eot <= 1'b0;
        end else begin
            Pos <= nxt_pos_s[W-1:0];
            Eot <= (nxt_pos_s == LAST_POS);
        end
    end

endmodule

// File: rtl/tape_seek_ctrl.sv
// Seek sequencer: turns one "seek to target [and play]" command into the
// PL/RE/FF/ST command stream for the tape transport, watching P/R/F for
// acknowledgement and tracking tape position.
module tape_seek_ctrl
    import tape_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int TAPE_LEN = DEF_TAPE_LEN,
    parameter int FF_STEP  = DEF_FF_STEP,
    parameter int RW_STEP  = DEF_RW_STEP,
    parameter int ACK_TO   = DEF_ACK_TO
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Go,
    input  logic [W-1:0] Target,
    input  logic         AutoPlay,
    input  logic         StopReq,
    input  logic         P,
    input  logic         R,
    input  logic         F,
    output logic         PL,
    output logic         RE,
    output logic         FF,
    output logic         ST,
    output logic [W-1:0] Pos,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic         Eot
);

    localparam logic [W:0]    LAST_POS = (W+1)'(TAPE_LEN - 1);
    localparam logic [W:0]    TAPE_END = (W+1)'(TAPE_LEN);
    localparam logic [W:0]    FF_INC   = (W+1)'(FF_STEP);
    localparam logic [W:0]    RW_DEC   = (W+1)'(RW_STEP);
    localparam int            TW       = $clog2(ACK_TO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TO - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    tape_state_e   state_r;
    logic [W-1:0]  tgt_r;
    logic          autoplay_r;
    logic          aborted_r;
    logic          acked_r;
    logic [TW-1:0] tmo_r;

    logic [W:0]    pos_ext_s;
    logic [W:0]    tgt_ext_s;
    logic [W-1:0]  go_tgt_s;
    logic [W:0]    go_ext_s;
    logic          fwd_need_s;
    logic          rew_need_s;
    logic          fwd_done_s;
    logic          rew_done_s;
    logic          fault_s;
    logic          moving_s;
    logic          tmo_exp_s;

    tape_pos_ctr #(
        .W        (W),
        .TAPE_LEN (TAPE_LEN),
        .FF_STEP  (FF_STEP),
        .RW_STEP  (RW_STEP)
    ) u_pos (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .P     (P),
        .R     (R),
        .F     (F),
        .Pos   (Pos),
        .Eot   (Eot)
    );

    // Target clamping and the distance comparisons used by the sequencer.
    always_comb begin
        pos_ext_s = {1'b0, Pos};
        tgt_ext_s = {1'b0, tgt_r};
        if ({1'b0, Target} >= TAPE_END) begin
            go_tgt_s = LAST_POS[W-1:0];
        end else begin
            go_tgt_s = Target;
        end
        go_ext_s   = {1'b0, go_tgt_s};
        fwd_need_s = (pos_ext_s + FF_INC) < go_ext_s;
        rew_need_s = pos_ext_s > (go_ext_s + RW_DEC);
        fwd_done_s = ((pos_ext_s + FF_INC) >= tgt_ext_s) || Eot;
        rew_done_s = (pos_ext_s <= (tgt_ext_s + RW_DEC)) || (Pos == {W{1'b0}});
        fault_s    = multi_hot3(P, R, F);
        moving_s   = P | R | F;
        tmo_exp_s  = (tmo_r == TMO_LAST);
    end

    // Sequencer FSM; every output is registered here alongside the state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r    <= IDLE;
            tgt_r      <= {W{1'b0}};
            autoplay_r <= 1'b0;
            aborted_r  <= 1'b0;
            acked_r    <= 1'b0;
            tmo_r      <= {TW{1'b0}};
            PL         <= 1'b0;
            RE         <= 1'b0;
            FF         <= 1'b0;
            ST         <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            RE   <= 1'b0;
            FF   <= 1'b0;
            ST   <= 1'b0;
            Done <= 1'b0;
            case (state_r)
                IDLE, ERR: begin
                    if (Go && !StopReq) begin
                        tgt_r      <= go_tgt_s;
                        autoplay_r <= AutoPlay;
                        aborted_r  <= 1'b0;
                        acked_r    <= 1'b0;
                        tmo_r      <= {TW{1'b0}};
                        Err        <= 1'b0;
                        if (fwd_need_s) begin
                            FF      <= 1'b1;
                            Busy    <= 1'b1;
                            state_r <= SEEK_FWD;
                        end else if (rew_need_s) begin
                            RE      <= 1'b1;
                            Busy    <= 1'b1;
                            state_r <= SEEK_REW;
                        end else if (AutoPlay) begin
                            PL      <= 1'b1;
                            Busy    <= 1'b1;
                            state_r <= PLAY_ARM;
                        end else begin
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else if (fault_s && (state_r == IDLE)) begin
                        ST      <= 1'b1;
                        Err     <= 1'b1;
                        PL      <= 1'b0;
                        Busy    <= 1'b0;
                        state_r <= ERR;
                    end else begin
                        state_r <= state_r;
                    end
                end

                SEEK_FWD, SEEK_REW: begin
                    if (fault_s ||
                        (!(acked_r || ((state_r == SEEK_FWD) ? F : R)) && tmo_exp_s &&
                         !StopReq && !((state_r == SEEK_FWD) ? fwd_done_s : rew_done_s))) begin
                        ST      <= 1'b1;
                        Err     <= 1'b1;
                        PL      <= 1'b0;
                        Busy    <= 1'b0;
                        state_r <= ERR;
                    end else if (StopReq) begin
                        ST        <= 1'b1;
                        PL        <= 1'b0;
                        aborted_r <= 1'b1;
                        tmo_r     <= {TW{1'b0}};
                        state_r   <= STOPPING;
                    end else if ((state_r == SEEK_FWD) ? fwd_done_s : rew_done_s) begin
                        ST      <= 1'b1;
                        tmo_r   <= {TW{1'b0}};
                        state_r <= STOPPING;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                        if ((state_r == SEEK_FWD) ? F : R) begin
                            acked_r <= 1'b1;
                        end else begin
                            acked_r <= acked_r;
                        end
                    end
                end

                STOPPING: begin
                    if (fault_s || (moving_s && tmo_exp_s)) begin
                        ST      <= 1'b1;
                        Err     <= 1'b1;
                        PL      <= 1'b0;
                        Busy    <= 1'b0;
                        state_r <= ERR;
                    end else if (!moving_s) begin
                        tmo_r <= {TW{1'b0}};
                        if (autoplay_r && !aborted_r) begin
                            PL      <= 1'b1;
                            state_r <= PLAY_ARM;
                        end else begin
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end

                PLAY_ARM: begin
                    if (fault_s || (!P && !StopReq && tmo_exp_s)) begin
                        ST      <= 1'b1;
                        Err     <= 1'b1;
                        PL      <= 1'b0;
                        Busy    <= 1'b0;
                        state_r <= ERR;
                    end else if (StopReq) begin
                        ST        <= 1'b1;
                        PL        <= 1'b0;
                        aborted_r <= 1'b1;
                        tmo_r     <= {TW{1'b0}};
                        state_r   <= STOPPING;
                    end else if (P) begin
                        tmo_r   <= {TW{1'b0}};
                        state_r <= PLAY;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end

                PLAY: begin
                    if (fault_s) begin
                        ST      <= 1'b1;
                        Err     <= 1'b1;
                        PL      <= 1'b0;
                        Busy    <= 1'b0;
                        state_r <= ERR;
                    end else if (StopReq || Eot) begin
                        ST         <= 1'b1;
                        PL         <= 1'b0;
                        autoplay_r <= 1'b0;
                        tmo_r      <= {TW{1'b0}};
                        state_r    <= STOPPING;
                    end else begin
                        state_r <= PLAY;
                    end
                end

                default: begin
                    PL      <= 1'b0;
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_seek_ctrl.sv
// Directed bench for tape_seek_ctrl with a transport model that answers
// each command one cycle later. Expected positions are hand-derived.
module tb_tape_seek_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Go;
    logic [15:0] Target;
    logic        AutoPlay;
    logic        StopReq;
    logic        P = 1'b0, R = 1'b0, F = 1'b0;
    logic        PL, RE, FF, ST, Busy, Done, Err, Eot;
    logic [15:0] Pos;

    logic        model_dead;
    logic        multi_cmd;
    logic        track_pl;
    logic        pl_seen;
    int          n_checks;
    int          n_pass;
    int          cyc;

    tape_seek_ctrl dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Go       (Go),
        .Target   (Target),
        .AutoPlay (AutoPlay),
        .StopReq  (StopReq),
        .P        (P),
        .R        (R),
        .F        (F),
        .PL       (PL),
        .RE       (RE),
        .FF       (FF),
        .ST       (ST),
        .Pos      (Pos),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err),
        .Eot      (Eot)
    );

    always #5 Clk = ~Clk;

    // Transport model: acknowledges FF/RE/ST one cycle later, P follows PL.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            P <= 1'b0; R <= 1'b0; F <= 1'b0;
        end else if (model_dead || ST) begin
            P <= 1'b0; R <= 1'b0; F <= 1'b0;
        end else begin
            if (FF) begin
                F <= 1'b1; R <= 1'b0;
            end else if (RE) begin
                R <= 1'b1; F <= 1'b0;
            end
            P <= PL;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        if ((RE & FF) | (RE & ST) | (FF & ST)) multi_cmd = 1'b1;
        if (track_pl && PL) pl_seen = 1'b1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0: return ST;
            1: return Done;
            2: return PL;
            default: return Err;
        endcase
    endfunction

    // Step until the selected output is 1 or the budget runs out; expiry fails.
    task automatic wait_until(input string tag, input int sel, input int limit, output int n);
        n = 0;
        while (pick(sel) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk(tag, 32'(pick(sel)), 32'd1);
    endtask

    task automatic go_cmd(input logic [15:0] t, input logic ap);
        Go = 1'b1; Target = t; AutoPlay = ap;
        step();
        Go = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; Go = 1'b0; Target = 16'd0; AutoPlay = 1'b0; StopReq = 1'b0;
        model_dead = 1'b0; multi_cmd = 1'b0; track_pl = 1'b0; pl_seen = 1'b0;
        n_checks = 0; n_pass = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pos", 32'(Pos), 32'd0);
        chk("rst_pl", 32'(PL), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_eot", 32'(Eot), 32'd0);
        chk("rst_cmds", 32'({RE, FF, ST, Done}), 32'd0);
        Rst_n = 1'b1;
        step();

        // Forward seek 0 -> 100, no play: ST seen at 100, one more FF step before stop.
        go_cmd(16'd100, 1'b0);
        chk("t1_ff_pulse", 32'(FF), 32'd1);
        chk("t1_re_quiet", 32'(RE), 32'd0);
        chk("t1_busy", 32'(Busy), 32'd1);
        wait_until("t1_st_seen", 0, 100, cyc);
        chk("t1_st_pos", 32'(Pos), 32'd100);
        wait_until("t1_done_seen", 1, 20, cyc);
        chk("t1_idle", 32'(Busy), 32'd0);
        chk("t1_final_pos", 32'(Pos), 32'd104);

        // Forward seek 104 -> 196 lands at 200.
        go_cmd(16'd196, 1'b0);
        wait_until("t1b_st_seen", 0, 100, cyc);
        chk("t1b_st_pos", 32'(Pos), 32'd196);
        wait_until("t1b_done_seen", 1, 20, cyc);
        chk("t1b_final_pos", 32'(Pos), 32'd200);

        // Rewind 200 -> 20 with AutoPlay: ST at 20, rest at 16, then play +1/cycle.
        go_cmd(16'd20, 1'b1);
        chk("t2_re_pulse", 32'(RE), 32'd1);
        chk("t2_ff_quiet", 32'(FF), 32'd0);
        wait_until("t2_st_seen", 0, 100, cyc);
        chk("t2_st_pos", 32'(Pos), 32'd20);
        wait_until("t2_pl_seen", 2, 20, cyc);
        chk("t2_pl_pos", 32'(Pos), 32'd16);
        repeat (3) step();
        chk("t2_play_pos", 32'(Pos), 32'd18);
        chk("t2_pl_held", 32'(PL), 32'd1);
        chk("t2_busy", 32'(Busy), 32'd1);

        // Asynchronous reset in the middle of play.
        #3 Rst_n = 1'b0;
        #1;
        chk("t6_rst_pl", 32'(PL), 32'd0);
        chk("t6_rst_pos", 32'(Pos), 32'd0);
        chk("t6_rst_busy", 32'(Busy), 32'd0);
        chk("t6_rst_st", 32'(ST), 32'd0);
        step();
        Rst_n = 1'b1;
        step();

        // Transport never answers FF: ERR on the 8th clock after acceptance.
        model_dead = 1'b1;
        go_cmd(16'd100, 1'b0);
        chk("t4_ff_pulse", 32'(FF), 32'd1);
        wait_until("t4_err_seen", 3, 20, cyc);
        chk("t4_err_cycles", 32'(cyc), 32'd8);
        chk("t4_err_st", 32'(ST), 32'd1);
        chk("t4_err_busy", 32'(Busy), 32'd0);
        model_dead = 1'b0;
        step();
        chk("t4_err_sticky", 32'(Err), 32'd1);
        go_cmd(16'd0, 1'b0);
        chk("t4_err_cleared", 32'(Err), 32'd0);
        chk("t4_go_done", 32'(Done), 32'd1);

        // Seek 0 -> 4088 then play into end of tape.
        go_cmd(16'd4088, 1'b1);
        chk("t3_ff_pulse", 32'(FF), 32'd1);
        wait_until("t3_pl_seen", 2, 1500, cyc);
        chk("t3_pl_pos", 32'(Pos), 32'd4092);
        wait_until("t3_st_seen", 0, 20, cyc);
        chk("t3_eot_pos", 32'(Pos), 32'd4095);
        chk("t3_eot_flag", 32'(Eot), 32'd1);
        chk("t3_pl_drop", 32'(PL), 32'd0);
        wait_until("t3_done_seen", 1, 20, cyc);
        chk("t3_idle", 32'(Busy), 32'd0);
        chk("t3_sat_pos", 32'(Pos), 32'd4095);

        // Target beyond tape end clamps to 4095: already there, so immediate Done.
        go_cmd(16'd5000, 1'b0);
        chk("t6_clamp_done", 32'(Done), 32'd1);
        chk("t6_clamp_no_ff", 32'(FF), 32'd0);
        chk("t6_clamp_idle", 32'(Busy), 32'd0);

        #2 Rst_n = 1'b0;
        #2;
        chk("t5_rst_pos", 32'(Pos), 32'd0);
        step();
        Rst_n = 1'b1;
        step();

        // StopReq during forward seek with AutoPlay: no play, Done; busy Go ignored.
        track_pl = 1'b1;
        go_cmd(16'd1000, 1'b1);
        chk("t5_ff_pulse", 32'(FF), 32'd1);
        repeat (5) step();
        go_cmd(16'd0, 1'b0);
        chk("t5_busy_go_cmds", 32'({RE, FF, ST}), 32'd0);
        chk("t5_busy_go_busy", 32'(Busy), 32'd1);
        step();
        chk("t5_busy_go_no_st", 32'(ST), 32'd0);
        StopReq = 1'b1;
        step();
        StopReq = 1'b0;
        chk("t5_abort_st", 32'(ST), 32'd1);
        chk("t5_abort_pl", 32'(PL), 32'd0);
        wait_until("t5_done_seen", 1, 20, cyc);
        chk("t5_idle", 32'(Busy), 32'd0);
        chk("t5_no_err", 32'(Err), 32'd0);
        repeat (3) step();
        track_pl = 1'b0;
        chk("t5_never_pl", 32'(pl_seen), 32'd0);

        chk("one_cmd_per_cycle", 32'(multi_cmd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
